// File: rtl/cajero_ctrl_param.sv
// ATM transaction controller: card accept, serial PIN entry with attempt limit and card block,
// then a deposit or withdrawal applied to a registered balance.
module cajero_ctrl_param #(
    parameter int PIN_DIGITOS  = 4,
    parameter int MAX_INTENTOS = 3,
    parameter int MONTO_W      = 32,
    parameter int BALANCE_W    = 64
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic                              tarjeta_recibida_i,
    input  logic [4*PIN_DIGITOS-1:0]          pin_correcto_i,
    input  logic                              digito_stb_i,
    input  logic [3:0]                        digito_i,
    input  logic                              tipo_trans_stb_i,
    input  logic                              tipo_trans_i,
    input  logic                              monto_stb_i,
    input  logic [MONTO_W-1:0]                monto_i,
    input  logic [BALANCE_W-1:0]              balance_inicial_i,
    output logic [BALANCE_W-1:0]              balance_o,
    output logic                              balance_actualizado_o,
    output logic                              entregar_dinero_o,
    output logic                              fondos_insuficientes_o,
    output logic                              pin_incorrecto_o,
    output logic                              advertencia_o,
    output logic                              bloqueo_o,
    output logic [$clog2(MAX_INTENTOS+1)-1:0] intentos_o,
    output logic                              fin_o
);

    localparam int IW = $clog2(MAX_INTENTOS + 1);
    localparam int CW = $clog2(PIN_DIGITOS + 1);
    localparam int PW = 4 * PIN_DIGITOS;
    localparam int SW = BALANCE_W + 1;

    typedef enum logic [3:0] {
        IDLE          = 4'd0,
        LEER_PIN      = 4'd1,
        VERIFICAR     = 4'd2,
        ESPERAR_TIPO  = 4'd3,
        ESPERAR_MONTO = 4'd4,
        DEPOSITO      = 4'd5,
        RETIRO        = 4'd6,
        FIN           = 4'd7,
        BLOQUEO       = 4'd8
    } estado_t;

    estado_t              state_q, state_d;
    logic [BALANCE_W-1:0] bal_q, bal_d;
    logic [PW-1:0]        pin_q, pin_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        int_q, int_d;
    logic                 tipo_q, tipo_d;
    logic [MONTO_W-1:0]   monto_q, monto_d;
    logic                 act_q, act_d, ent_q, ent_d, fon_q, fon_d;
    logic                 pinbad_q, pinbad_d, adv_q, adv_d, bloq_q, bloq_d, fin_q, fin_d;
    logic [PW+3:0]        shift_s;
    logic [BALANCE_W:0]   suma_s;

    // Next-state, datapath and output-pulse decode.
    always_comb begin
        state_d  = state_q;
        bal_d    = bal_q;
        pin_d    = pin_q;
        cnt_d    = cnt_q;
        int_d    = int_q;
        tipo_d   = tipo_q;
        monto_d  = monto_q;
        act_d    = 1'b0;
        ent_d    = 1'b0;
        fon_d    = 1'b0;
        pinbad_d = 1'b0;
        fin_d    = 1'b0;
        shift_s  = {pin_q, digito_i};
        // One extra bit catches the carry so a deposit saturates instead of wrapping.
        suma_s   = {1'b0, bal_q} + SW'(monto_q);

        case (state_q)
            IDLE: begin
                if (tarjeta_recibida_i) begin
                    state_d = LEER_PIN;
                    bal_d   = balance_inicial_i;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            LEER_PIN: begin
                if (digito_stb_i) begin
                    pin_d = shift_s[PW-1:0];
                    if (cnt_q == CW'(PIN_DIGITOS - 1)) begin
                        state_d = VERIFICAR;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    state_d = LEER_PIN;
                end
            end
            VERIFICAR: begin
                if (pin_q == pin_correcto_i) begin
                    state_d = ESPERAR_TIPO;
                    int_d   = '0;
                end else begin
                    pinbad_d = 1'b1;
                    int_d    = int_q + IW'(1);
                    cnt_d    = '0;
                    if (int_q == IW'(MAX_INTENTOS - 1)) begin
                        state_d = BLOQUEO;
                    end else begin
                        state_d = LEER_PIN;
                    end
                end
            end
            ESPERAR_TIPO: begin
                if (tipo_trans_stb_i) begin
                    tipo_d  = tipo_trans_i;
                    state_d = ESPERAR_MONTO;
                end else begin
                    state_d = ESPERAR_TIPO;
                end
            end
            ESPERAR_MONTO: begin
                if (monto_stb_i) begin
                    monto_d = monto_i;
                    state_d = tipo_q ? RETIRO : DEPOSITO;
                end else begin
                    state_d = ESPERAR_MONTO;
                end
            end
            DEPOSITO: begin
                bal_d   = suma_s[BALANCE_W] ? {BALANCE_W{1'b1}} : suma_s[BALANCE_W-1:0];
                act_d   = 1'b1;
                state_d = FIN;
            end
            RETIRO: begin
                if (BALANCE_W'(monto_q) <= bal_q) begin
                    bal_d = bal_q - BALANCE_W'(monto_q);
                    act_d = 1'b1;
                    ent_d = 1'b1;
                end else begin
                    fon_d = 1'b1;
                end
                state_d = FIN;
            end
            FIN: begin
                fin_d   = 1'b1;
                state_d = IDLE;
            end
            BLOQUEO: begin
                state_d = BLOQUEO;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        adv_d  = (MAX_INTENTOS > 1) ? (int_d == IW'(MAX_INTENTOS - 1)) : 1'b0;
        bloq_d = (state_d == BLOQUEO);
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            bal_q    <= '0;
            pin_q    <= '0;
            cnt_q    <= '0;
            int_q    <= '0;
            tipo_q   <= 1'b0;
            monto_q  <= '0;
            act_q    <= 1'b0;
            ent_q    <= 1'b0;
            fon_q    <= 1'b0;
            pinbad_q <= 1'b0;
            adv_q    <= 1'b0;
            bloq_q   <= 1'b0;
            fin_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            bal_q    <= bal_d;
            pin_q    <= pin_d;
            cnt_q    <= cnt_d;
            int_q    <= int_d;
            tipo_q   <= tipo_d;
            monto_q  <= monto_d;
            act_q    <= act_d;
            ent_q    <= ent_d;
            fon_q    <= fon_d;
            pinbad_q <= pinbad_d;
            adv_q    <= adv_d;
            bloq_q   <= bloq_d;
            fin_q    <= fin_d;
        end
    end

    assign balance_o              = bal_q;
    assign balance_actualizado_o  = act_q;
    assign entregar_dinero_o      = ent_q;
    assign fondos_insuficientes_o = fon_q;
    assign pin_incorrecto_o       = pinbad_q;
    assign advertencia_o          = adv_q;
    assign bloqueo_o              = bloq_q;
    assign intentos_o             = int_q;
    assign fin_o                  = fin_q;

endmodule

// File: tb/tb_cajero_ctrl_param.sv
// Bench for cajero_ctrl_param: transaction outcomes go through an expected/observed scoreboard,
// PIN attempt, block and reset behaviour are compared inline by each scenario task.
module tb_cajero_ctrl_param;

    localparam int P  = 4;
    localparam int MI = 3;
    localparam int MW = 32;
    localparam int BW = 64;
    localparam int IW = $clog2(MI + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          tarjeta, digito_stb, tipo_stb, tipo, monto_stb;
    logic [4*P-1:0] pin_correcto;
    logic [3:0]    digito;
    logic [MW-1:0] monto;
    logic [BW-1:0] balance_inicial, balance;
    logic          act, ent, fon, pinbad, adv, bloq, fin;
    logic [IW-1:0] intentos;

    always #5 clk = ~clk;

    cajero_ctrl_param #(.PIN_DIGITOS(P), .MAX_INTENTOS(MI), .MONTO_W(MW), .BALANCE_W(BW)) dut (
        .clk_i(clk), .reset_i(reset), .tarjeta_recibida_i(tarjeta), .pin_correcto_i(pin_correcto),
        .digito_stb_i(digito_stb), .digito_i(digito), .tipo_trans_stb_i(tipo_stb),
        .tipo_trans_i(tipo), .monto_stb_i(monto_stb), .monto_i(monto),
        .balance_inicial_i(balance_inicial), .balance_o(balance),
        .balance_actualizado_o(act), .entregar_dinero_o(ent), .fondos_insuficientes_o(fon),
        .pin_incorrecto_o(pinbad), .advertencia_o(adv), .bloqueo_o(bloq),
        .intentos_o(intentos), .fin_o(fin)
    );

    typedef struct packed {
        logic [BW-1:0] bal;
        logic          act;
        logic          ent;
        logic          fon;
    } res_t;

    res_t exp_q[$];
    res_t obs_q[$];
    int checks = 0;
    int failures = 0;
    logic [BW-1:0] mdl_bal;
    logic acc_act = 1'b0, acc_ent = 1'b0, acc_fon = 1'b0;

    // Monitor: gathers pulses of one transaction and records the outcome when fin fires.
    always @(negedge clk) begin
        if (reset) begin
            acc_act <= 1'b0;
            acc_ent <= 1'b0;
            acc_fon <= 1'b0;
        end else if (fin) begin
            obs_q.push_back({balance, acc_act | act, acc_ent | ent, acc_fon | fon});
            acc_act <= 1'b0;
            acc_ent <= 1'b0;
            acc_fon <= 1'b0;
        end else begin
            acc_act <= acc_act | act;
            acc_ent <= acc_ent | ent;
            acc_fon <= acc_fon | fon;
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic insert_card(input logic [BW-1:0] bi);
        balance_inicial = bi;
        mdl_bal = bi;
        tarjeta = 1'b1;
        tick();
        tarjeta = 1'b0;
    endtask

    task automatic enter_pin(input logic [4*P-1:0] p);
        logic [4*P-1:0] v;
        v = p;
        for (int i = 0; i < P; i++) begin
            digito_stb = 1'b1;
            digito = v[4*P-1-4*i -: 4];
            tick();
        end
        digito_stb = 1'b0;
        tick();
    endtask

    task automatic do_trans(input logic t, input logic [MW-1:0] m);
        res_t e;
        logic [BW:0] s;
        e = '0;
        if (t == 1'b0) begin
            s = {1'b0, mdl_bal} + {{(BW + 1 - MW){1'b0}}, m};
            mdl_bal = s[BW] ? {BW{1'b1}} : s[BW-1:0];
            e.act = 1'b1;
        end else if ({{(BW - MW){1'b0}}, m} <= mdl_bal) begin
            mdl_bal = mdl_bal - {{(BW - MW){1'b0}}, m};
            e.act = 1'b1;
            e.ent = 1'b1;
        end else begin
            e.fon = 1'b1;
        end
        e.bal = mdl_bal;
        exp_q.push_back(e);
        tipo_stb = 1'b1;
        tipo = t;
        tick();
        tipo_stb = 1'b0;
        monto_stb = 1'b1;
        monto = m;
        tick();
        monto_stb = 1'b0;
    endtask

    task automatic wait_obs(output bit ok);
        for (int i = 0; i < 20 && obs_q.size() == 0; i++) tick();
        ok = (obs_q.size() > 0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if ({balance, act, ent, fon, pinbad, adv, bloq, intentos, fin} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got bal=%0d act=%b ent=%b fon=%b pinbad=%b adv=%b bloq=%b int=%0d fin=%b expected all 0",
                     balance, act, ent, fon, pinbad, adv, bloq, intentos, fin);
        end
    endtask

    task automatic test_deposit();
        bit ok;
        res_t o, e;
        insert_card(64'd1000);
        enter_pin(16'h1234);
        checks++;
        if (pinbad !== 1'b0 || intentos !== IW'(0)) begin
            failures++;
            $display("FAIL deposit_pin got pinbad=%b int=%0d expected 0 0", pinbad, intentos);
        end
        do_trans(1'b0, 32'd500);
        wait_obs(ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL deposit_timeout got no fin expected fin within 20 cycles");
        end else begin
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL deposit_result got bal=%0d act=%b ent=%b fon=%b expected bal=%0d act=%b ent=%b fon=%b",
                         o.bal, o.act, o.ent, o.fon, e.bal, e.act, e.ent, e.fon);
            end
            tick();
            checks++;
            if (fin !== 1'b0 || balance !== 64'd1500) begin
                failures++;
                $display("FAIL deposit_after_fin got fin=%b bal=%0d expected fin=0 bal=1500", fin, balance);
            end
        end
    endtask

    task automatic test_withdraw(input string name, input logic [BW-1:0] bi, input logic t,
                                 input logic [MW-1:0] m);
        bit ok;
        res_t o, e;
        insert_card(bi);
        enter_pin(16'h1234);
        do_trans(t, m);
        wait_obs(ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s_timeout got no fin expected fin within 20 cycles", name);
        end else begin
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL %s_result got bal=%0d act=%b ent=%b fon=%b expected bal=%0d act=%b ent=%b fon=%b",
                         name, o.bal, o.act, o.ent, o.fon, e.bal, e.act, e.ent, e.fon);
            end
        end
    endtask

    task automatic test_block();
        logic exp_adv, exp_bloq;
        insert_card(64'd1000);
        for (int k = 1; k <= MI; k++) begin
            enter_pin((k == 2) ? 16'h12A4 : 16'h9999);
            exp_adv  = (k == MI - 1);
            exp_bloq = (k == MI);
            checks++;
            if (pinbad !== 1'b1 || intentos !== IW'(k) || adv !== exp_adv || bloq !== exp_bloq) begin
                failures++;
                $display("FAIL block_attempt%0d got pinbad=%b int=%0d adv=%b bloq=%b expected 1 %0d %b %b",
                         k, pinbad, intentos, adv, bloq, k, exp_adv, exp_bloq);
            end
        end
        tarjeta = 1'b1;
        tick();
        tarjeta = 1'b0;
        enter_pin(16'h1234);
        tipo_stb = 1'b1;
        monto_stb = 1'b1;
        tick();
        tick();
        tipo_stb = 1'b0;
        monto_stb = 1'b0;
        checks++;
        if (bloq !== 1'b1 || pinbad !== 1'b0 || intentos !== IW'(MI) || act !== 1'b0 || obs_q.size() != 0) begin
            failures++;
            $display("FAIL block_sticky got bloq=%b pinbad=%b int=%0d act=%b fins=%0d expected 1 0 %0d 0 0",
                     bloq, pinbad, intentos, act, obs_q.size(), MI);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if (bloq !== 1'b0 || intentos !== IW'(0)) begin
            failures++;
            $display("FAIL block_reset got bloq=%b int=%0d expected 0 0", bloq, intentos);
        end
    endtask

    task automatic test_retry();
        bit ok;
        res_t o, e;
        insert_card(64'd1000);
        enter_pin(16'h4321);
        checks++;
        if (pinbad !== 1'b1 || intentos !== IW'(1) || adv !== 1'b0) begin
            failures++;
            $display("FAIL retry_wrong got pinbad=%b int=%0d adv=%b expected 1 1 0", pinbad, intentos, adv);
        end
        enter_pin(16'h1234);
        checks++;
        if (pinbad !== 1'b0 || intentos !== IW'(0) || adv !== 1'b0) begin
            failures++;
            $display("FAIL retry_right got pinbad=%b int=%0d adv=%b expected 0 0 0", pinbad, intentos, adv);
        end
        do_trans(1'b0, 32'd50);
        wait_obs(ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL retry_timeout got no fin expected fin within 20 cycles");
        end else begin
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL retry_result got bal=%0d act=%b expected bal=%0d act=%b",
                         o.bal, o.act, e.bal, e.act);
            end
        end
    endtask

    task automatic test_reset_mid();
        insert_card(64'd2000);
        enter_pin(16'h1234);
        tipo_stb = 1'b1;
        tipo = 1'b1;
        tick();
        tipo_stb = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({balance, act, ent, fon, pinbad, adv, bloq, intentos, fin} !== '0) begin
            failures++;
            $display("FAIL reset_mid_async got bal=%0d int=%0d expected all 0", balance, intentos);
        end
        tick();
        reset = 1'b0;
        digito_stb = 1'b1;
        digito = 4'd1;
        monto_stb = 1'b1;
        monto = 32'd5;
        for (int i = 0; i < 4; i++) tick();
        digito_stb = 1'b0;
        monto_stb = 1'b0;
        tick();
        checks++;
        if (balance !== '0 || act !== 1'b0 || ent !== 1'b0 || pinbad !== 1'b0 || obs_q.size() != 0) begin
            failures++;
            $display("FAIL reset_mid_idle_ignore got bal=%0d act=%b ent=%b pinbad=%b fins=%0d expected 0 0 0 0 0",
                     balance, act, ent, pinbad, obs_q.size());
        end
    endtask

    initial begin
        reset = 1'b0;
        tarjeta = 1'b0;
        digito_stb = 1'b0;
        digito = 4'd0;
        tipo_stb = 1'b0;
        tipo = 1'b0;
        monto_stb = 1'b0;
        monto = '0;
        balance_inicial = '0;
        pin_correcto = 16'h1234;
        mdl_bal = '0;
        #1;
        reset = 1'b1;
        tick();
        test_reset();
        test_deposit();
        test_withdraw("withdraw", 64'd1000, 1'b1, 32'd300);
        test_withdraw("insufficient", 64'd1000, 1'b1, 32'd1200);
        test_withdraw("exact", 64'd1000, 1'b1, 32'd1000);
        test_withdraw("saturate", 64'hFFFF_FFFF_FFFF_FF00, 1'b0, 32'h0000_1000);
        test_block();
        test_retry();
        test_reset_mid();
        test_withdraw("after_reset", 64'd700, 1'b0, 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
